// File: rtl/vigenere_pkg.sv
// Shared constants, state encoding and key-shift helpers for the Vigenere stream controller.
package vigenere_pkg;

  localparam logic [7:0] ASCII_A = 8'd65;
  localparam logic [7:0] ASCII_Z = 8'd90;
  localparam int unsigned ALPHA_SIZE = 26;
  localparam int unsigned DEFAULT_MAX_KEY_LEN = 10;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam logic [0:0] ST_NOKEY = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  typedef enum logic [0:0] {
    NOKEY = ST_NOKEY,
    RUN   = ST_RUN
  } state_t;

  function automatic logic isLetter(input logic [7:0] c);
    return (c >= ASCII_A) && (c <= ASCII_Z);
  endfunction

  // Key characters outside 'A'..'Z' contribute no shift.
  function automatic logic [4:0] keyShift(input logic [7:0] c);
    return isLetter(c) ? 5'(c - ASCII_A) : 5'd0;
  endfunction

endpackage

// File: rtl/vigenere_stream_controller_if.sv
// Character stream handshake bundle: input side (source -> controller) and output side (controller -> sink).
interface vigenere_stream_controller_if;
  logic [7:0] IN_CHAR;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] OUT_CHAR;
  logic       OUT_VALID;
  logic       OUT_READY;

  modport master (
    output IN_CHAR, IN_VALID, OUT_READY,
    input  IN_READY, OUT_CHAR, OUT_VALID
  );

  modport slave (
    input  IN_CHAR, IN_VALID, OUT_READY,
    output IN_READY, OUT_CHAR, OUT_VALID
  );
endinterface

// File: rtl/caesar_shift_unit.sv
// Combinational single-letter Caesar stage: encrypt adds the shift, decrypt subtracts it, modulo 26.
module caesar_shift_unit
  import vigenere_pkg::*;
(
  input  logic [7:0] letter,
  input  logic [4:0] shift,
  input  logic       mode,
  output logic [7:0] result
);

  logic [4:0] p;
  logic [5:0] sum;
  logic [5:0] wrapped;

  always_comb begin
    p       = 5'(letter - ASCII_A);
    sum     = (mode == MODE_DEC) ? (6'(p) + 6'(ALPHA_SIZE) - 6'(shift))
                                 : (6'(p) + 6'(shift));
    wrapped = (sum >= 6'(ALPHA_SIZE)) ? (sum - 6'(ALPHA_SIZE)) : sum;
    result  = {2'b00, wrapped} + ASCII_A;
  end

endmodule

// File: rtl/vigenere_stream_controller.sv
// Vigenere stream controller: key load, key-index sequencing and 1-deep output register.
// Optional macro VIGENERE_PASSTHRU_EN forwards non-letters instead of dropping them.
module vigenere_stream_controller
  import vigenere_pkg::*;
#(
  parameter int unsigned MAX_KEY_LEN = DEFAULT_MAX_KEY_LEN
)(
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     LOAD,
  input  logic [8*MAX_KEY_LEN-1:0] KEY_IN,
  input  logic [3:0]               KEY_LEN,
  input  logic                     MODE,
  vigenere_stream_controller_if.slave stream,
  output logic [3:0]               KEY_IDX,
  output logic                     ERR
);

`ifdef VIGENERE_PASSTHRU_EN
  localparam logic PASSTHRU = 1'b1;
`else
  localparam logic PASSTHRU = 1'b0;
`endif

  localparam logic [3:0] MAX_LEN4 = 4'(MAX_KEY_LEN);

  state_t                   state;
  logic [8*MAX_KEY_LEN-1:0] keyReg;
  logic [3:0]               keyLen;
  logic [7:0]               outChar;
  logic                     outValid;

  logic       inReady;
  logic       xfer;
  logic       inIsLetter;
  logic       loadOk;
  logic       emit;
  logic [7:0] keyChar;
  logic [4:0] shiftVal;
  logic [7:0] shifted;

  assign keyChar    = keyReg[{KEY_IDX, 3'b000} +: 8];
  assign shiftVal   = keyShift(keyChar);
  assign inIsLetter = isLetter(stream.IN_CHAR);
  assign loadOk     = (KEY_LEN != 4'd0) && (KEY_LEN <= MAX_LEN4);
  assign inReady    = (state == RUN) && !LOAD && (!outValid || stream.OUT_READY);
  assign xfer       = stream.IN_VALID && inReady;
  assign emit       = inIsLetter || PASSTHRU;

  assign stream.IN_READY  = inReady;
  assign stream.OUT_CHAR  = outChar;
  assign stream.OUT_VALID = outValid;

  caesar_shift_unit u_shift (
    .letter (stream.IN_CHAR),
    .shift  (shiftVal),
    .mode   (MODE),
    .result (shifted)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= NOKEY;
      keyReg   <= '0;
      keyLen   <= '0;
      KEY_IDX  <= '0;
      outChar  <= '0;
      outValid <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      ERR <= 1'b0;

      // LOAD blocks acceptance via inReady, so load and transfer never coincide.
      if (LOAD) begin
        if (loadOk) begin
          state   <= RUN;
          keyReg  <= KEY_IN;
          keyLen  <= KEY_LEN;
          KEY_IDX <= '0;
        end else begin
          ERR <= 1'b1;
        end
      end

      if (xfer && emit) begin
        outValid <= 1'b1;
        outChar  <= inIsLetter ? shifted : stream.IN_CHAR;
      end else if (stream.OUT_READY) begin
        outValid <= 1'b0;
      end

      if (xfer && inIsLetter)
        KEY_IDX <= (KEY_IDX == keyLen - 4'd1) ? '0 : KEY_IDX + 4'd1;

      if (xfer && !inIsLetter && !PASSTHRU)
        ERR <= 1'b1;
    end
  end

endmodule

// File: doc/vigenere_stream_controller.md
# vigenere_stream_controller

Sequencing controller for the character-cipher datapath. It holds a loaded Vigenère key and accepts a stream of uppercase ASCII characters through a valid/ready handshake. For each character it selects the current key character, drives one Caesar shift stage (encrypt or decrypt), and advances a key index that wraps at the programmed key length. It sits between a character source (UART/testbench) and a character sink, replacing per-character manual key shifting.

## Interface
- Parameters:
- MAX_KEY_LEN, 10: maximum key characters; KEY_IN width is 8*MAX_KEY_LEN.
- Ports:
- CLK  input  1  rising-edge clock; the block's only clock.
- RESET  input  1  synchronous, active-high reset.
- LOAD  input  1  key-load strobe, sampled on CLK.
- KEY_IN  input  80  key characters; char 0 is KEY_IN[7:0], char i is KEY_IN[8i+7:8i].
- KEY_LEN  input  4  number of valid key chars, 1..MAX_KEY_LEN.
- MODE  input  1  0 = encrypt, 1 = decrypt; sampled at input acceptance.
- IN_CHAR  input  8  ASCII input character.
- IN_VALID  input  1  IN_CHAR valid.
- IN_READY  output  1  block accepts IN_CHAR this cycle.
- OUT_CHAR  output  8  ASCII result.
- OUT_VALID  output  1  OUT_CHAR valid.
- OUT_READY  input  1  sink accepts OUT_CHAR.
- KEY_IDX  output  4  index of the key char used for the next letter.
- ERR  output  1  one-cycle pulse on a rejected load or a dropped character.

## Operation
- States:
  - NOKEY: after reset, no key held.
  - RUN: key held.
- Transitions:
  - NOKEY -> RUN on LOAD with a valid KEY_LEN.
  - RUN -> RUN on LOAD: reload the key.
  - RESET from any state -> NOKEY.
- Load acceptance:
  - Valid KEY_LEN is 1..MAX_KEY_LEN. The key register and length are captured and KEY_IDX is set to 0.
  - KEY_LEN of 0 or above MAX_KEY_LEN rejects the load: state and key are unchanged and ERR pulses.
- Key shift: shift = key char - 65. A key char outside 'A'..'Z' gives shift 0.
- Letter path, for IN_CHAR in 'A'..'Z' (65..90), with p = IN_CHAR - 65 (5 bits):
  - Encrypt: s = p + shift (6 bits). If s >= 26, subtract 26. OUT = s + 65.
  - Decrypt: s = p + 26 - shift (6 bits). If s >= 26, subtract 26. OUT = s + 65.
- KEY_IDX advance after each accepted letter: KEY_IDX + 1, wrapping to 0 when it reaches KEY_LEN - 1.
- Non-letter handling: see Configuration.
- MODE may change between characters. The key index is not reset by a MODE change.
- Simultaneous LOAD and IN_VALID: LOAD wins. IN_READY is 0 in that cycle. A pending OUT_CHAR/OUT_VALID is unaffected by LOAD.

## Timing
- Reset values:
  - OUT_CHAR = 8'd0, OUT_VALID = 0, IN_READY = 0, KEY_IDX = 0, ERR = 0.
  - State is NOKEY and the key register is cleared.
- Handshake:
  - IN_READY = (state == RUN) && !LOAD && (!OUT_VALID || OUT_READY). This is combinational from registered state and LOAD/OUT_READY.
  - A transfer happens when IN_VALID && IN_READY on a rising CLK edge.
  - The output register loads at the same edge. OUT_VALID is high from the next cycle, so latency is 1 cycle.
  - Throughput is 1 char/cycle while OUT_READY stays high.
- OUT_VALID clears on an OUT_READY edge with no new transfer.
- OUT_CHAR is stable while OUT_VALID && !OUT_READY.
- KEY_IDX updates at the transfer edge.
- ERR is high exactly one cycle after the offending edge.
- RESET mid-stream drops any pending output (OUT_VALID = 0 the next cycle) and requires a new LOAD.

## Configuration
- Macro: VIGENERE_PASSTHRU_EN.
- Defined: a non-letter IN_CHAR is accepted, forwarded unchanged to OUT_CHAR with normal 1-cycle latency, and KEY_IDX does not advance. ERR stays 0.
- Undefined: a non-letter IN_CHAR is accepted (consumed) but produces no output. OUT_VALID is unchanged by it, KEY_IDX does not advance, and ERR pulses.

## Structure
- Package vigenere_pkg holds:
  - ASCII_A = 8'd65, ASCII_Z = 8'd90.
  - ALPHA_SIZE = 26, MAX_KEY_LEN default.
  - MODE_ENC/MODE_DEC constants.
  - The state enum (NOKEY, RUN).
- Sub-module caesar_shift_unit: combinational. Inputs are letter[7:0], shift[4:0] and mode; output is result[7:0], implementing the letter-path arithmetic above. The controller instantiates one copy.
- The controller itself holds the state register, key register, length/index counter, output register and handshake logic.

## Test plan
- Basic encrypt: LOAD key "LEMON", KEY_LEN 5, MODE 0, then stream "ATTACKATDAWN" with OUT_READY=1 -> "LXFOPVEFRNHR". Each output arrives 1 cycle after its input. KEY_IDX follows 0,1,2,3,4,0,...
- Decrypt round trip: reload "LEMON", MODE 1, stream "LXFOPVEFRNHR" -> "ATTACKATDAWN".
- Alphabet wrap:
  - Key "B", KEY_LEN 1, encrypt 'Z' -> 'A'.
  - Decrypt 'A' -> 'Z'.
  - Key "A" leaves 'Q' unchanged.
- Backpressure: hold OUT_READY=0 for 3 cycles after the first output -> OUT_CHAR and OUT_VALID are held and IN_READY=0. When OUT_READY returns to 1, the next char is accepted in the same cycle and no character is lost or duplicated.
- Load and error cases:
  - LOAD with KEY_LEN 11 in NOKEY -> ERR pulse, IN_READY stays 0.
  - LOAD together with IN_VALID -> char not accepted, KEY_IDX = 0.
  - RESET asserted mid-stream -> OUT_VALID 0 next cycle, state NOKEY.
- Non-letter handling: key "BC", stream 'A',' ','B'.
  - With VIGENERE_PASSTHRU_EN -> 'B',' ','D'.
  - Without it -> 'B','D' plus one ERR pulse.
